cpu_run_ctrl: RTL

Command-side controller that drives the CPU run/stop interface, i.e. the initiator for the CPU status block's cpu_start/quit_cmd inputs. It accepts single-byte commands from the debug/UART command path and issues one-cycle cpu_start or quit_cmd pulses. It supports a bounded single-step run of N cycles, watches the returned cpu_run_state for confirmation, and returns a one-byte response through a valid/ready handshake.

---
 rtl/cpu_run_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/stop command controller: turns single-byte debug commands into cpu_start/quit_cmd
// pulses, supervises the returned cpu_run_state and answers with a one-byte response.
module cpu_run_ctrl #(
  parameter int STEP_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_code,
  input  logic [STEP_W-1:0] cmd_arg,
  input  logic              cpu_run_state,
  output logic              cpu_start,
  output logic              quit_cmd,
  output logic              resp_valid,
  output logic [7:0]        resp_data,
  input  logic              resp_ready,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_RUN, S_STEPPING, S_QUIT, S_WAIT_STOP, S_RESP
  } state_t;

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_UNK = 8'h3F;

  state_t              r_state;
  logic                r_is_step;
  logic [STEP_W-1:0]   r_arg;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_cpu_start;
  logic                r_quit_pre;
  logic                r_resp_valid;
  logic [7:0]          r_resp_data;

  logic                w_accept;
  logic [STEP_W:0]     w_k;
  logic [STEP_W:0]     w_k_next;
  logic [STEP_W:0]     w_arg_ext;

  assign cmd_ready  = (r_state == S_IDLE) && !rst;
  assign busy       = (r_state != S_IDLE);
  assign cpu_start  = r_cpu_start;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  // The quit request is armed one cycle early and only fires while the CPU is seen running,
  // so a CPU that never started is never told to stop.
  assign quit_cmd   = r_quit_pre && cpu_run_state;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_arg_ext = {1'b0, r_arg};
  // w_k is the index of the current high cycle while stepping (one extra bit: no wrap at N=2^STEP_W-1).
  assign w_k       = {1'b0, r_step_cnt} + (STEP_W + 1)'(1);
  assign w_k_next  = w_k + (STEP_W + 1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_is_step    <= 1'b0;
      r_arg        <= '0;
      r_step_cnt   <= '0;
      r_to_cnt     <= '0;
      r_cpu_start  <= 1'b0;
      r_quit_pre   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_step  <= 1'b0;
            r_arg      <= cmd_arg;
            r_step_cnt <= '0;
            r_to_cnt   <= '0;
            case (cmd_code)
              8'h67: begin
                if (cpu_run_state) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_data  <= RSP_OK;
                end else begin
                  r_cpu_start <= 1'b1;
                  r_state     <= S_START;
                end
              end
              8'h71: begin
                if (!cpu_run_state) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_data  <= RSP_OK;
                end else begin
                  r_quit_pre <= 1'b1;
                  r_state    <= S_QUIT;
                end
              end
              8'h73: begin
                if ((cmd_arg == '0) || cpu_run_state) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_data  <= RSP_ERR;
                end else begin
                  r_is_step   <= 1'b1;
                  r_cpu_start <= 1'b1;
                  r_state     <= S_START;
                end
              end
              8'h72: begin
                r_state      <= S_RESP;
                r_resp_valid <= 1'b1;
                r_resp_data  <= {7'b0011000, cpu_run_state};
              end
              default: begin
                r_state      <= S_RESP;
                r_resp_valid <= 1'b1;
                r_resp_data  <= RSP_UNK;
              end
            endcase
          end
        end

        S_START: begin
          r_cpu_start <= 1'b0;
          r_quit_pre  <= r_is_step && (r_arg == STEP_W'(1));
          r_state     <= S_WAIT_RUN;
        end

        S_WAIT_RUN: begin
          if (cpu_run_state) begin
            if (!r_is_step) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_data  <= RSP_OK;
            end else if (r_arg == STEP_W'(1)) begin
              r_quit_pre <= 1'b0;
              r_to_cnt   <= '0;
              r_state    <= S_WAIT_STOP;
            end else begin
              r_step_cnt <= STEP_W'(1);
              r_quit_pre <= (r_arg == STEP_W'(2));
              r_state    <= S_STEPPING;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_quit_pre   <= 1'b0;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_data  <= RSP_ERR;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        S_STEPPING: begin
          if (!cpu_run_state) begin
            r_quit_pre   <= 1'b0;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_data  <= RSP_ERR;
          end else if (w_k == w_arg_ext) begin
            r_quit_pre <= 1'b0;
            r_to_cnt   <= '0;
            r_state    <= S_WAIT_STOP;
          end else begin
            r_step_cnt <= w_k[STEP_W-1:0];
            r_quit_pre <= (w_k_next == w_arg_ext);
          end
        end

        S_QUIT: begin
          r_quit_pre <= 1'b0;
          r_to_cnt   <= '0;
          r_state    <= S_WAIT_STOP;
        end

        S_WAIT_STOP: begin
          if (!cpu_run_state) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_data  <= RSP_OK;
          end else if (r_to_cnt == TO_LAST) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_data  <= RSP_ERR;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
